// File: rtl/ch_buf.sv
// ch_buf: 5-entry out-of-order request buffer; in_* enqueue to lowest free slot, out_* issue first eligible entry from read_ptr, bank_busy_i blocks banks, entry_valid_o/read_ptr_o/count_o expose state
module ch_buf #(
  parameter int DATA_W = 64,
  parameter int BANK_W = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [DATA_W-1:0]    in_data_i,
  input  logic [BANK_W-1:0]    in_bank_i,
  input  logic [2**BANK_W-1:0] bank_busy_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DATA_W-1:0]    out_data_o,
  output logic [BANK_W-1:0]    out_bank_o,
  output logic [2:0]           out_entry_o,
  output logic [4:0]           entry_valid_o,
  output logic [2:0]           read_ptr_o,
  output logic [2:0]           count_o
);
  logic [DATA_W-1:0] data_q [5];
  logic [BANK_W-1:0] bank_q [5];
  logic [4:0] valid_q, elig, set_m, clr_m;
  logic [2:0] ptr_q, cnt_q, sel, wr;
  logic [2:0] rot [5];
  logic enq, deq;
  for (genvar i = 0; i < 5; i++) begin : g_rot
    logic [3:0] t;
    assign t = {1'b0, ptr_q} + 4'(i);
    assign rot[i] = t >= 4'd5 ? 3'(t - 4'd5) : t[2:0];
  end
  always_comb begin
    elig = '0;
    for (int k = 0; k < 5; k++) elig[k] = valid_q[k] & ~bank_busy_i[bank_q[k]];
  end
  always_comb begin
    sel = ptr_q;
    for (int i = 4; i >= 0; i--) if (elig[rot[i]]) sel = rot[i];
  end
  always_comb begin
    wr = '0;
    for (int k = 4; k >= 0; k--) if (!valid_q[k]) wr = 3'(k);
  end
  assign in_ready_o    = cnt_q != 3'd5;
  assign out_valid_o   = |elig;
  assign out_entry_o   = sel;
  assign out_data_o    = data_q[sel];
  assign out_bank_o    = bank_q[sel];
  assign entry_valid_o = valid_q;
  assign read_ptr_o    = ptr_q;
  assign count_o       = cnt_q;
  assign enq   = in_valid_i & in_ready_o;
  assign deq   = out_valid_o & out_ready_i;
  assign set_m = enq ? 5'(1) << wr : '0;
  assign clr_m = deq ? 5'(1) << sel : '0;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= (valid_q | set_m) & ~clr_m;
      ptr_q   <= deq ? (sel == 3'd4 ? 3'd0 : sel + 3'd1) : ptr_q;
      cnt_q   <= cnt_q + 3'(enq) - 3'(deq);
    end
  end
  always_ff @(posedge clk_i) begin
    if (enq) begin
      data_q[wr] <= in_data_i;
      bank_q[wr] <= in_bank_i;
    end
  end
endmodule

// File: tb/tb_ch_buf.sv
// tb_ch_buf: randomized and directed check of ch_buf against a slot-array reference model
module tb_ch_buf;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst, in_valid, in_ready, out_valid, out_ready;
  logic [63:0] in_data, out_data;
  logic [1:0] in_bank, out_bank;
  logic [3:0] busy;
  logic [2:0] out_entry, read_ptr, count;
  logic [4:0] entry_valid;
  ch_buf dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .in_bank_i(in_bank), .bank_busy_i(busy),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_bank_o(out_bank), .out_entry_o(out_entry), .entry_valid_o(entry_valid),
    .read_ptr_o(read_ptr), .count_o(count)
  );
  int n_chk = 0, n_pass = 0;
  bit mv [5];
  logic [63:0] md [5];
  logic [1:0] mb [5];
  int mp, mc;
  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask
  function automatic int msel(logic [3:0] b);
    for (int j = 0; j < 5; j++) begin
      int k = (mp + j) % 5;
      if (mv[k] && !b[mb[k]]) return k;
    end
    return -1;
  endfunction
  function automatic int mfree();
    for (int k = 0; k < 5; k++) if (!mv[k]) return k;
    return -1;
  endfunction
  task automatic step(bit iv, logic [63:0] d, logic [1:0] b, logic [3:0] bb, bit ordy);
    int s, w;
    bit e, q;
    logic [4:0] ev;
    @(negedge clk);
    in_valid = iv; in_data = d; in_bank = b; busy = bb; out_ready = ordy;
    #1;
    s = msel(bb);
    w = mfree();
    ev = '0;
    for (int k = 0; k < 5; k++) ev[k] = mv[k];
    check("in_ready", in_ready, mc != 5);
    check("out_valid", out_valid, s >= 0);
    check("out_entry", out_entry, s >= 0 ? s : mp);
    if (s >= 0) begin
      check("out_data", out_data, md[s]);
      check("out_bank", out_bank, mb[s]);
    end
    check("entry_valid", entry_valid, ev);
    check("read_ptr", read_ptr, mp);
    check("count", count, mc);
    check("popcount", count, $countones(entry_valid));
    e = iv && mc != 5;
    q = s >= 0 && ordy;
    if (q) begin mv[s] = 0; mp = (s + 1) % 5; end
    if (e) begin mv[w] = 1; md[w] = d; mb[w] = b; end
    mc = mc + int'(e) - int'(q);
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1; in_valid = 0; out_ready = 1; busy = '0;
    @(posedge clk);
    #1;
    rst = 0;
    for (int k = 0; k < 5; k++) mv[k] = 0;
    mp = 0; mc = 0;
    check("rst_valid", entry_valid, 5'b0);
    check("rst_count", count, 3'd0);
    check("rst_ptr", read_ptr, 3'd0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_entry", out_entry, 3'd0);
    check("rst_in_ready", in_ready, 1'b1);
  endtask
  initial begin
    rst = 0; in_valid = 0; in_data = '0; in_bank = '0; busy = '0; out_ready = 0;
    for (int k = 0; k < 5; k++) begin mv[k] = 0; md[k] = '0; mb[k] = '0; end
    mp = 0; mc = 0;
    do_reset();
    step(1, 64'hAAAA, 0, 0, 0);
    step(1, 64'hBBBB, 1, 0, 0);
    step(1, 64'hCCCC, 2, 0, 0);
    check("fill_valid", entry_valid, 5'b00111);
    check("fill_count", count, 3'd3);
    check("fill_entry", out_entry, 3'd0);
    check("fill_data", out_data, 64'hAAAA);
    step(1, 64'hDDDD, 3, 0, 0);
    step(1, 64'hEEEE, 0, 0, 0);
    check("full_count", count, 3'd5);
    check("full_ready", in_ready, 1'b0);
    step(1, 64'hFFFF, 1, 0, 0);
    check("full_hold", count, 3'd5);
    step(0, 0, 0, 0, 1);
    check("deq_ready", in_ready, 1'b1);
    do_reset();
    step(1, 64'h10, 1, 0, 0);
    step(1, 64'h11, 2, 4'b0010, 0);
    check("blk_entry", out_entry, 3'd1);
    step(0, 0, 0, 4'b0010, 1);
    check("blk_ptr", read_ptr, 3'd2);
    step(0, 0, 0, 4'b0000, 0);
    check("blk_wrap", out_entry, 3'd0);
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 64'h20 + 64'(i), 2'(i), 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
    step(1, 64'h30, 0, 0, 0);
    check("wrap_ptr", read_ptr, 3'd4);
    check("wrap_valid", entry_valid, 5'b10001);
    step(0, 0, 0, 0, 1);
    check("wrap_ptr0", read_ptr, 3'd0);
    step(0, 0, 0, 0, 1);
    check("wrap_ptr1", read_ptr, 3'd1);
    check("wrap_empty", out_valid, 1'b0);
    do_reset();
    step(1, 64'h40, 0, 0, 0);
    step(1, 64'h41, 0, 0, 0);
    step(1, 64'h42, 1, 0, 0);
    step(1, 64'h43, 2, 0, 0);
    step(1, 64'h44, 0, 0, 0);
    step(0, 0, 0, 4'b1011, 1);
    check("sim_pre_count", count, 3'd4);
    step(1, 64'hD0, 3, 4'b1101, 1);
    check("sim_valid", entry_valid, 5'b11011);
    check("sim_count", count, 3'd4);
    step(0, 0, 0, 4'b1111, 0);
    check("sim_data", md[3], 64'hD0);
    step(0, 0, 0, 4'b0111, 0);
    check("sim_slot", out_data, 64'hD0);
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(99) == 0) do_reset();
      else step($urandom_range(9) < 6, {$urandom, $urandom}, 2'($urandom_range(3)),
                4'($urandom_range(15)) & 4'($urandom_range(15)), $urandom_range(1) == 1);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ch_buf.md
Name: ch_buf

Overview:
- 5-entry request buffer for one crossbar channel, upstream of the channel's round-robin entry selector.
- Accepts requests in order and stores each with a target bank id.
- Issues requests out of order: each cycle it picks the first eligible entry, scanning from a rotating read pointer. An entry is eligible when it is valid and its bank is not busy.
- Owns entry valid bits, read pointer, occupancy count and payload storage.

Parameters:
- DATA_W, 64, payload width in bits.
- BANK_W, 2, bank id width. The busy mask is 2**BANK_W bits.
- Entry count is fixed at 5. Pointers are 3 bits wide and always hold values 0..4.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous reset, active-high.
- in_valid_i  input  1  upstream request valid.
- in_ready_o  output  1  buffer can accept a request.
- in_data_i  input  DATA_W  request payload.
- in_bank_i  input  BANK_W  request target bank.
- bank_busy_i  input  2**BANK_W  per-bank busy; a busy bank blocks its entries this cycle.
- out_valid_o  output  1  an eligible entry is presented.
- out_ready_i  input  1  downstream accepts the presented entry.
- out_data_o  output  DATA_W  payload of the selected entry.
- out_bank_o  output  BANK_W  bank of the selected entry.
- out_entry_o  output  3  index (0..4) of the selected entry.
- entry_valid_o  output  5  valid bit per entry.
- read_ptr_o  output  3  current read pointer.
- count_o  output  3  occupied entries, 0..5.

Behaviour:
- Reset: while rst_i is high at a clock edge, entry_valid clears to 0, read_ptr to 0 and count to 0. After reset: in_ready_o=1, out_valid_o=0, out_entry_o=0, entry_valid_o=0, read_ptr_o=0, count_o=0. Payload and bank registers are not reset.
- Reset mid-operation discards all entries; nothing is issued in the reset cycle.
- in_ready_o = (count != 5). It depends on registered state only; there is no bypass from a same-cycle dequeue.
- Enqueue fires when in_valid_i & in_ready_o.
  - The write slot is the lowest-index entry that is free in the current registered entry_valid.
  - On fire: store data and bank, set valid.
- Eligibility: elig[k] = entry_valid[k] & ~bank_busy_i[bank[k]].
- Selection: scan k = read_ptr, read_ptr+1, ..., read_ptr+4 (mod 5, so 4 wraps to 0). The first eligible entry is selected.
  - out_valid_o = |elig. This is combinational from state and bank_busy_i, with zero-cycle latency.
  - When nothing is eligible, out_entry_o = read_ptr and out_data_o/out_bank_o are don't-care.
- Dequeue fires when out_valid_o & out_ready_i.
  - On fire: clear entry_valid[sel] and set read_ptr to (sel+1) mod 5, so sel=4 gives 0.
  - With no dequeue, read_ptr holds.
- Simultaneous enqueue and dequeue:
  - Both occur in the same cycle.
  - The write slot is chosen from the pre-dequeue free set, so the slot being freed is never reused that cycle.
  - count holds.
- count updates: +1 on enqueue only, -1 on dequeue only, unchanged when both or neither occur.
- No output stability guarantee: the presented entry may change while out_ready_i is low, because bank_busy_i or read_ptr-relative eligibility can change. Downstream must sample only on fire.
- Full (count=5): enqueue is blocked; dequeue still allowed.
- Empty: out_valid_o=0.
- All valid entries blocked: out_valid_o=0 and read_ptr holds.
- Invariant: count = popcount(entry_valid). The bench asserts this every cycle.

Test Plan:
- Ordered fill: reset; enqueue A(bank0), B(bank1), C(bank2) on consecutive cycles; out_ready_i=0, busy=0 -> entry_valid_o=00111, count_o=3, out_valid_o=1, out_entry_o=0, out_data_o=A.
- Full backpressure: enqueue 5 requests -> count_o=5, in_ready_o=0. A 6th request is held upstream. One dequeue -> in_ready_o=1 the next cycle.
- Bank blocking: entry0 bank1, entry1 bank2, bank_busy_i=0010 -> out_entry_o=1. Dequeue -> read_ptr_o=2. Clear busy -> out_entry_o=0, selected via wrap-around from ptr 2.
- Wrap: read_ptr=4, entries 4 and 0 valid, out_ready_i=1 -> entry 4 issues then read_ptr=0; entry 0 issues next cycle then read_ptr=1; out_valid_o=0 after.
- Simultaneous enq/deq: count=4 with entry 3 free; dequeue entry 2 and enqueue D in the same cycle -> D lands in entry 3, entry 2 becomes free, count_o stays 4.
- Reset mid-operation: 3 entries valid with out_ready_i=1, assert rst_i for one cycle -> no dequeue that cycle; next cycle entry_valid_o=0, count_o=0, read_ptr_o=0, out_valid_o=0, in_ready_o=1.
